// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, handshaked backing memory between the instruction-fetch stage
//   and the data-memory stage. Data accesses win by default; a streak counter forces one fetch
//   grant after FAIR_LIMIT consecutive data grants made while a fetch was waiting. A memory
//   that never acknowledges is aborted after TIMEOUT busy cycles and flagged on err.
//   All state updates on the falling edge of CLK, matching the pipeline registers.
//
// Ports
//   CLK, Reset_L          clock (negedge active), asynchronous active-low reset
//   if_req/if_addr        fetch request and byte address
//   if_rdata/if_valid     fetched word and its one-cycle completion pulse
//   if_stall              fetch stall, combinational
//   d_read/d_write        load / store request (both set = store)
//   d_addr/d_wdata        data byte address and store data
//   d_rdata/d_valid       load word and its one-cycle completion pulse
//   d_stall               data stall, combinational
//   mem_req/mem_we        backing-memory request and write enable (registered)
//   mem_addr/mem_wdata    word-aligned address and store data of the granted access
//   mem_ack/mem_rdata     memory completion and read data
//   err                   sticky timeout flag
module mem_port_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam logic [3:0] FairMax  = 4'(FAIR_LIMIT);
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_t;

    state_t      state;
    state_t      nextState;
    logic [3:0]  streak;
    logic [7:0]  waitCnt;
    logic        dReq;
    logic        grantI;
    logic        grantD;
    logic        ackDone;
    logic        timedOut;
    logic        finish;

    assign dReq     = d_read | d_write;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = dReq & ~d_valid;
    assign finish   = ackDone | timedOut;

    // State register
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle: begin
                if (grantD) begin
                    nextState = StBusyD;
                end else if (grantI) begin
                    nextState = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (finish) begin
                    nextState = StResp;
                end
            end
            StResp:  nextState = StIdle;
            default: nextState = StIdle;
        endcase
    end

    // Control decode: grants in IDLE, completion/abort in BUSY
    always_comb begin
        grantI   = 1'b0;
        grantD   = 1'b0;
        ackDone  = 1'b0;
        timedOut = 1'b0;
        unique case (state)
            StIdle: begin
                // Fetch wins a contested slot only once the data streak has saturated
                if (dReq && !(if_req && streak == FairMax)) begin
                    grantD = 1'b1;
                end else if (if_req) begin
                    grantI = 1'b1;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ack) begin
                    ackDone = 1'b1;
                end else if (waitCnt == WaitLast) begin
                    timedOut = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            err       <= 1'b0;
            streak    <= '0;
            waitCnt   <= '0;
        end else begin
            if (grantD) begin
                mem_req   <= 1'b1;
                mem_we    <= d_write;
                mem_addr  <= d_addr & ~32'h3;
                mem_wdata <= d_wdata;
                waitCnt   <= '0;
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != FairMax) begin
                    streak <= streak + 4'd1;
                end
            end else if (grantI) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr & ~32'h3;
                waitCnt  <= '0;
                streak   <= '0;
            end

            if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == StBusyI) begin
                    if_valid <= 1'b1;
                    if_rdata <= timedOut ? 32'h0 : mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    // A completed store leaves the last load word untouched
                    if (timedOut) begin
                        d_rdata <= '0;
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end else if (state == StBusyI || state == StBusyD) begin
                waitCnt <= waitCnt + 8'd1;
            end

            if (timedOut) begin
                err <= 1'b1;
            end

            if (state == StResp) begin
                if_valid <= 1'b0;
                d_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (FAIR_LIMIT=4, TIMEOUT=8). The DUT acts on negedge
// CLK; the bench samples and drives on posedge, half a cycle away from the active edge.
module tb_mem_port_arbiter;

    logic        CLK = 1'b1;
    logic        Reset_L;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    // Memory model: acks once mem_req has been seen on ackEdge posedges (1 = grant cycle)
    logic        ackOn;
    int          ackEdge;
    int          reqAge;
    logic [31:0] memData;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) reqAge <= mem_req ? reqAge + 1 : 0;

    assign mem_ack   = ackOn && mem_req && (reqAge >= ackEdge);
    assign mem_rdata = memData;

    mem_port_arbiter #(
        .FAIR_LIMIT(4),
        .TIMEOUT   (8)
    ) dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_stall  (d_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
    endtask

    logic [31:0] fairExp [10];

    initial begin
        Reset_L = 1'b0;
        if_req  = 1'b1;
        if_addr = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        ackOn   = 1'b1;
        ackEdge = 1;
        reqAge  = 0;
        memData = '0;

        // Reset state
        cyc();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_if_stall", 32'(if_stall), 32'd1);
        check("rst_d_stall", 32'(d_stall), 32'd0);
        if_req  = 1'b0;
        Reset_L = 1'b1;
        cyc();

        // Fetch only, zero-wait memory, two back-to-back fetches
        if_req  = 1'b1;
        if_addr = 32'h0040_0006;
        memData = 32'h8C22_0004;
        cyc();
        check("f1_mem_req", 32'(mem_req), 32'd1);
        check("f1_mem_addr", mem_addr, 32'h0040_0004);
        check("f1_mem_we", 32'(mem_we), 32'd0);
        check("f1_if_stall", 32'(if_stall), 32'd1);
        cyc();
        check("f1_if_valid", 32'(if_valid), 32'd1);
        check("f1_if_rdata", if_rdata, 32'h8C22_0004);
        check("f1_if_stall_resp", 32'(if_stall), 32'd0);
        check("f1_mem_req_resp", 32'(mem_req), 32'd0);
        if_addr = 32'h0040_0008;
        memData = 32'h0000_0001;
        cyc();
        check("f2_idle_valid", 32'(if_valid), 32'd0);
        check("f2_idle_req", 32'(mem_req), 32'd0);
        check("f2_idle_stall", 32'(if_stall), 32'd1);
        cyc();
        check("f2_mem_req", 32'(mem_req), 32'd1);
        check("f2_mem_addr", mem_addr, 32'h0040_0008);
        cyc();
        check("f2_if_valid", 32'(if_valid), 32'd1);
        check("f2_if_rdata", if_rdata, 32'h0000_0001);
        if_req = 1'b0;
        cyc();
        check("f2_valid_fall", 32'(if_valid), 32'd0);
        check("f2_stall_fall", 32'(if_stall), 32'd0);

        // Simultaneous fetch and store: store first, fetch three cycles later
        if_req  = 1'b1;
        if_addr = 32'h0040_0010;
        d_write = 1'b1;
        d_addr  = 32'h0000_0010;
        d_wdata = 32'hCAFE_F00D;
        memData = 32'hDEAD_BEEF;
        cyc();
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_mem_addr", mem_addr, 32'h0000_0010);
        check("sw_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check("sw_if_stall_busy", 32'(if_stall), 32'd1);
        check("sw_d_stall_busy", 32'(d_stall), 32'd1);
        cyc();
        check("sw_d_valid", 32'(d_valid), 32'd1);
        check("sw_d_rdata_kept", d_rdata, 32'h0);
        check("sw_d_stall_resp", 32'(d_stall), 32'd0);
        check("sw_if_stall_resp", 32'(if_stall), 32'd1);
        d_write = 1'b0;
        cyc();
        check("sw_if_stall_idle", 32'(if_stall), 32'd1);
        cyc();
        check("sw_fetch_req", 32'(mem_req), 32'd1);
        check("sw_fetch_we", 32'(mem_we), 32'd0);
        check("sw_fetch_addr", mem_addr, 32'h0040_0010);
        cyc();
        check("sw_fetch_valid", 32'(if_valid), 32'd1);
        check("sw_fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0;
        cyc();

        // Fairness: both held, grant order D,D,D,D,I,D,D,D,D,I
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        d_read  = 1'b1;
        d_addr  = 32'h0000_0200;
        memData = 32'h55AA_55AA;
        for (int g = 0; g < 10; g++) begin
            fairExp[g] = (g == 4 || g == 9) ? 32'h0000_0100 : 32'h0000_0200;
        end
        for (int g = 0; g < 10; g++) begin
            cyc();
            check($sformatf("fair_grant%0d", g), mem_addr, fairExp[g]);
            cyc();
            cyc();
        end
        if_req = 1'b0;
        d_read = 1'b0;
        cyc();

        // Timeout on a load: abort at the 8th edge after the grant
        d_read = 1'b1;
        d_addr = 32'h0000_0040;
        ackOn  = 1'b0;
        cyc();
        check("to_grant_req", 32'(mem_req), 32'd1);
        for (int j = 1; j < 8; j++) begin
            cyc();
            check($sformatf("to_wait%0d_req", j), 32'(mem_req), 32'd1);
        end
        check("to_wait_no_valid", 32'(d_valid), 32'd0);
        check("to_wait_no_err", 32'(err), 32'd0);
        cyc();
        check("to_req_fall", 32'(mem_req), 32'd0);
        check("to_d_valid", 32'(d_valid), 32'd1);
        check("to_d_rdata", d_rdata, 32'h0);
        check("to_err", 32'(err), 32'd1);
        d_read = 1'b0;
        ackOn  = 1'b1;
        cyc();
        check("to_valid_fall", 32'(d_valid), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);

        // Wait states: ack seen on the 5th edge after the grant
        d_read  = 1'b1;
        d_addr  = 32'h0000_0080;
        memData = 32'h1234_5678;
        ackEdge = 5;
        for (int j = 0; j < 5; j++) begin
            cyc();
            check($sformatf("ws_stall%0d", j), 32'(d_stall), 32'd1);
            check($sformatf("ws_novalid%0d", j), 32'(d_valid), 32'd0);
        end
        cyc();
        check("ws_d_valid", 32'(d_valid), 32'd1);
        check("ws_d_rdata", d_rdata, 32'h1234_5678);
        check("ws_stall_resp", 32'(d_stall), 32'd0);
        check("ws_err_sticky", 32'(err), 32'd1);
        d_read  = 1'b0;
        ackEdge = 1;
        cyc();
        check("ws_valid_one_cycle", 32'(d_valid), 32'd0);

        // Asynchronous reset during BUSY_D, then pending fetch granted on first negedge
        d_read  = 1'b1;
        d_addr  = 32'h0000_0300;
        ackOn   = 1'b0;
        cyc();
        check("rb_busy_req", 32'(mem_req), 32'd1);
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        memData = 32'h0000_5555;
        #2 Reset_L = 1'b0;
        #1;
        check("rb_async_req", 32'(mem_req), 32'd0);
        check("rb_async_addr", mem_addr, 32'h0);
        check("rb_async_err", 32'(err), 32'd0);
        check("rb_async_d_rdata", d_rdata, 32'h0);
        d_read = 1'b0;
        ackOn  = 1'b1;
        #1 Reset_L = 1'b1;
        cyc();
        check("rb_fetch_req", 32'(mem_req), 32'd1);
        check("rb_fetch_addr", mem_addr, 32'h0000_0500);
        check("rb_fetch_we", 32'(mem_we), 32'd0);
        cyc();
        check("rb_fetch_valid", 32'(if_valid), 32'd1);
        check("rb_fetch_rdata", if_rdata, 32'h0000_5555);
        if_req = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
